div_issuer: RTL and testbench
=============================

DIV_ISSUER -- requirements
Module: div_issuer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand and quotient width in bits.
REQ-002 SHALL have parameter DEPTH, default 4 (power of 2), meaning operand FIFO entries.
REQ-003 SHALL have parameter TIMEOUT, default 64, meaning the maximum number of WAIT cycles before a job is abandoned.
REQ-004 SHALL have ports: clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports: s_valid  in  1  operand pair offered; s_ready  out  1  operand pair accepted; s_num  in  WIDTH  signed numerator; s_den  in  WIDTH  signed denominator.
REQ-006 SHALL have ports: m_valid  out  1  result offered; m_ready  in  1  result consumed; m_quot  out  WIDTH  quotient; m_dz  out  1  divide-by-zero flag; m_to  out  1  timeout flag.
REQ-007 SHALL have ports: div_rst  out  1  divider reset; div_in_valid  out  1  start pulse; div_N  out  WIDTH  numerator; div_D  out  WIDTH  denominator; div_ready  in  1  divider idle; div_out_valid  in  1  divider done (held until divider reset); div_out  in  WIDTH  divider quotient.

Function
REQ-008 SHALL accept an operand pair into the FIFO on any clk edge with s_valid && s_ready; s_ready = !fifo_full.
REQ-009 SHALL keep FIFO order; push and pop in the same cycle SHALL be legal, with count unchanged.
REQ-010 SHALL implement FSM states IDLE, ISSUE, WAIT, RESULT, CLEAR.
REQ-011 IDLE with FIFO non-empty and head den == 0 SHALL pop the head and go to RESULT with m_quot = 0x7FF..F if num >= 0, else 0x800..0, m_dz = 1, and m_to = 0; the divider SHALL NOT be started.
REQ-012 IDLE with FIFO non-empty, head den != 0 and div_ready = 1 SHALL go to ISSUE; with div_ready = 0 it SHALL stay in IDLE.
REQ-013 ISSUE SHALL last exactly 1 cycle: div_in_valid = 1, div_N/div_D = head operands, head popped, then go to WAIT.
REQ-014 div_N/div_D SHALL be registered and remain stable from ISSUE until the next ISSUE.
REQ-015 WAIT SHALL count cycles from 0. When div_out_valid = 1, it SHALL capture div_out into m_quot, clear m_dz/m_to, and go to RESULT.
REQ-016 WAIT with the counter reaching TIMEOUT-1 and no div_out_valid SHALL go to RESULT with m_quot = 0 and m_to = 1; div_out_valid in that same cycle SHALL take priority over the timeout.
REQ-017 RESULT SHALL hold m_valid = 1 with stable m_quot/m_dz/m_to until m_ready = 1.
REQ-018 On the RESULT handshake, the FSM SHALL go to CLEAR if the divider was started for this job; for a dz job it SHALL go to IDLE.
REQ-019 CLEAR SHALL assert div_rst for exactly 1 cycle, then go to IDLE; div_rst SHALL otherwise equal rst.
REQ-020 Minimum latency from push into an empty FIFO to ISSUE SHALL be 2 cycles (push edge, IDLE decision).
REQ-021 Only one divide SHALL ever be outstanding.
REQ-022 div_in_valid SHALL never assert outside ISSUE.

Reset
REQ-023 rst SHALL force state to IDLE, empty the FIFO, zero the WAIT counter, and set s_ready = 0 during reset and 1 after.
REQ-024 rst SHALL set m_valid = 0, m_quot = 0, m_dz = 0, m_to = 0, div_in_valid = 0, div_N = 0, div_D = 0.
REQ-025 rst SHALL drive div_rst = 1 while rst = 1.
REQ-026 rst mid-WAIT or mid-RESULT SHALL discard the job without producing a result.

Structure
REQ-027 State encoding and saturation constants (QMAX, QMIN) SHALL live in a shared package div_pkg.
REQ-028 The FIFO SHALL be a sub-module op_fifo (WIDTH*2 data, DEPTH entries, full/empty/count).
REQ-029 The FSM, WAIT counter and result registers SHALL be in div_issuer.

Verification
REQ-030 Push (num = 0x00060000, den = 0x00020000) to a divider model returning 0x30000000 after 40 cycles -> one ISSUE pulse, m_quot = 0x30000000, m_dz = 0, then a 1-cycle div_rst.
REQ-031 Push (5, 0) and (-5, 0) -> m_quot = 0x7FFFFFFF then 0x80000000, m_dz = 1, no div_in_valid, no div_rst.
REQ-032 Push 5 pairs back-to-back with DEPTH = 4 and the divider busy -> s_ready low after 4 pushes, all 5 results delivered in order.
REQ-033 Divider model never asserts div_out_valid -> m_to = 1 and m_quot = 0 after 64 WAIT cycles, then CLEAR, and the next job proceeds.
REQ-034 Hold m_ready = 0 for 10 cycles in RESULT -> m_valid and m_quot stable, no new ISSUE. Then assert rst for 1 cycle mid-WAIT -> m_valid = 0, FIFO empty, div_rst = 1.

Source files
------------

// File: rtl/div_pkg.sv
// div_pkg: shared definitions for the divider issuer.
//   state_t    - issuer FSM state encoding
//   QW         - widest supported quotient width
//   QMAX/QMIN  - QW-bit saturation constants; narrower widths take them
//                right-shifted by (QW - WIDTH)
package div_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESULT,
        ST_CLEAR
    } state_t;

    localparam int unsigned QW = 64;

    localparam logic [QW-1:0] QMAX = {1'b0, {(QW-1){1'b1}}};
    localparam logic [QW-1:0] QMIN = {1'b1, {(QW-1){1'b0}}};

endpackage

// File: rtl/op_fifo.sv
// op_fifo: synchronous operand FIFO, DEPTH entries (power of 2, >= 2).
//   clk, rst    - clock, synchronous active-high reset (empties the FIFO)
//   push, din   - write; ignored while full
//   pop, dout   - read; dout is the current head (valid when !empty)
//   full, empty - occupancy flags
//   count       - number of stored entries
module op_fifo #(
    parameter int unsigned DW    = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DW-1:0]            din,
    input  logic                     pop,
    output logic [DW-1:0]            dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of 2.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/div_issuer.sv
// div_issuer: queues signed operand pairs and issues them one at a time to
// an external multi-cycle divider, returning quotient plus divide-by-zero
// and timeout flags.
//   clk, rst                      - clock, synchronous active-high reset
//   s_valid/s_ready/s_num/s_den   - operand input handshake
//   m_valid/m_ready/m_quot/m_dz/m_to - result output handshake
//   div_rst, div_in_valid, div_N, div_D - divider control and operands
//   div_ready, div_out_valid, div_out   - divider status and quotient
module div_issuer
    import div_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_num,
    input  logic [WIDTH-1:0] s_den,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_quot,
    output logic             m_dz,
    output logic             m_to,
    output logic             div_rst,
    output logic             div_in_valid,
    output logic [WIDTH-1:0] div_N,
    output logic [WIDTH-1:0] div_D,
    input  logic             div_ready,
    input  logic             div_out_valid,
    input  logic [WIDTH-1:0] div_out
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CNTW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [QW-1:0] QMAX_W = QMAX >> (QW - WIDTH);
    localparam logic [QW-1:0] QMIN_W = QMIN >> (QW - WIDTH);

    logic [2*WIDTH-1:0] fifo_dout;
    logic               fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [AW:0]        fifo_count;
    logic [WIDTH-1:0]   head_num, head_den;

    state_t           state_q, state_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             m_valid_q, m_valid_d;
    logic [WIDTH-1:0] m_quot_q, m_quot_d;
    logic             m_dz_q, m_dz_d;
    logic             m_to_q, m_to_d;
    logic             started_q, started_d;
    logic             div_in_valid_q, div_in_valid_d;
    logic [WIDTH-1:0] div_num_q, div_num_d;
    logic [WIDTH-1:0] div_den_q, div_den_d;

    assign head_num  = fifo_dout[2*WIDTH-1:WIDTH];
    assign head_den  = fifo_dout[WIDTH-1:0];
    assign s_ready   = !rst && !fifo_full;
    assign fifo_push = s_valid && s_ready;
    // Zero-denominator jobs are consumed straight from IDLE; others leave
    // the FIFO during ISSUE, when the head is already latched into div_N/D.
    assign fifo_pop  = (state_q == ST_ISSUE) ||
                       (state_q == ST_IDLE && !fifo_empty && head_den == '0);

    op_fifo #(
        .DW    (2*WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   ({s_num, s_den}),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (fifo_full == (fifo_count == (AW+1)'(DEPTH)));
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        m_valid_d      = m_valid_q;
        m_quot_d       = m_quot_q;
        m_dz_d         = m_dz_q;
        m_to_d         = m_to_q;
        started_d      = started_q;
        div_in_valid_d = 1'b0;
        div_num_d      = div_num_q;
        div_den_d      = div_den_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    if (head_den == '0) begin
                        state_d   = ST_RESULT;
                        m_valid_d = 1'b1;
                        m_quot_d  = head_num[WIDTH-1] ? QMIN_W[WIDTH-1:0]
                                                      : QMAX_W[WIDTH-1:0];
                        m_dz_d    = 1'b1;
                        m_to_d    = 1'b0;
                        started_d = 1'b0;
                    end else if (div_ready) begin
                        state_d        = ST_ISSUE;
                        div_in_valid_d = 1'b1;
                        div_num_d      = head_num;
                        div_den_d      = head_den;
                    end
                end
            end
            ST_ISSUE: begin
                state_d   = ST_WAIT;
                cnt_d     = '0;
                started_d = 1'b1;
            end
            ST_WAIT: begin
                if (div_out_valid) begin
                    state_d   = ST_RESULT;
                    m_valid_d = 1'b1;
                    m_quot_d  = div_out;
                    m_dz_d    = 1'b0;
                    m_to_d    = 1'b0;
                end else if (cnt_q == CNTW'(TIMEOUT - 1)) begin
                    state_d   = ST_RESULT;
                    m_valid_d = 1'b1;
                    m_quot_d  = '0;
                    m_dz_d    = 1'b0;
                    m_to_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            ST_RESULT: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    state_d   = started_q ? ST_CLEAR : ST_IDLE;
                end
            end
            ST_CLEAR: begin
                state_d   = ST_IDLE;
                started_d = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            m_valid_q      <= 1'b0;
            m_quot_q       <= '0;
            m_dz_q         <= 1'b0;
            m_to_q         <= 1'b0;
            started_q      <= 1'b0;
            div_in_valid_q <= 1'b0;
            div_num_q      <= '0;
            div_den_q      <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            m_valid_q      <= m_valid_d;
            m_quot_q       <= m_quot_d;
            m_dz_q         <= m_dz_d;
            m_to_q         <= m_to_d;
            started_q      <= started_d;
            div_in_valid_q <= div_in_valid_d;
            div_num_q      <= div_num_d;
            div_den_q      <= div_den_d;
        end
    end

    assign m_valid      = m_valid_q;
    assign m_quot       = m_quot_q;
    assign m_dz         = m_dz_q;
    assign m_to         = m_to_q;
    assign div_in_valid = div_in_valid_q;
    assign div_N        = div_num_q;
    assign div_D        = div_den_q;
    assign div_rst      = rst || (state_q == ST_CLEAR);

endmodule

// File: tb/tb_div_issuer.sv
module tb_div_issuer;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid, s_ready;
    logic [31:0] s_num, s_den;
    logic        m_valid, m_ready;
    logic [31:0] m_quot;
    logic        m_dz, m_to;
    logic        div_rst, div_in_valid;
    logic [31:0] div_N, div_D;
    logic        div_ready, div_out_valid;
    logic [31:0] div_out;

    int checks = 0;
    int errors = 0;

    // divider model state
    int          lat        = 40;
    logic        never_done = 1'b0;
    logic        hold_busy  = 1'b0;
    logic        mdl_busy   = 1'b0;
    logic        mdl_done   = 1'b0;
    int          mdl_cnt    = 0;
    logic [31:0] mdl_res    = '0;
    int          issue_cnt  = 0;
    int          divrst_cnt = 0;
    int          overlap_cnt = 0;

    always #5 clk = ~clk;

    div_issuer #(
        .WIDTH   (32),
        .DEPTH   (4),
        .TIMEOUT (64)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_num         (s_num),
        .s_den         (s_den),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_quot        (m_quot),
        .m_dz          (m_dz),
        .m_to          (m_to),
        .div_rst       (div_rst),
        .div_in_valid  (div_in_valid),
        .div_N         (div_N),
        .div_D         (div_D),
        .div_ready     (div_ready),
        .div_out_valid (div_out_valid),
        .div_out       (div_out)
    );

    // Fixed-point divider model: integer quotient placed at bit 28.
    function automatic logic [31:0] model_div(input logic [31:0] n, input logic [31:0] d);
        logic signed [31:0] q;
        q = $signed(n) / $signed(d);
        return q << 28;
    endfunction

    assign div_ready     = !mdl_busy && !mdl_done && !hold_busy;
    assign div_out_valid = mdl_done;
    assign div_out       = mdl_res;

    always @(posedge clk) begin
        if (div_rst) begin
            mdl_busy <= 1'b0;
            mdl_done <= 1'b0;
            mdl_cnt  <= 0;
        end else if (div_in_valid) begin
            if (mdl_busy || mdl_done) overlap_cnt <= overlap_cnt + 1;
            mdl_busy <= 1'b1;
            mdl_cnt  <= 0;
            mdl_res  <= model_div(div_N, div_D);
        end else if (mdl_busy && !never_done) begin
            if (mdl_cnt >= lat - 1) begin
                mdl_busy <= 1'b0;
                mdl_done <= 1'b1;
            end else begin
                mdl_cnt <= mdl_cnt + 1;
            end
        end
        issue_cnt  <= issue_cnt + int'(div_in_valid);
        divrst_cnt <= divrst_cnt + int'(div_rst && !rst);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] n, input logic [31:0] d);
        int g = 0;
        s_valid = 1'b1;
        s_num   = n;
        s_den   = d;
        while (!s_ready && g < 300) begin
            step();
            g++;
        end
        checks++;
        if (!s_ready) begin
            errors++;
            $display("FAIL push_accept: s_ready=%b required 1", s_ready);
        end
        step();
        s_valid = 1'b0;
    endtask

    task automatic wait_result(input string name, input logic [31:0] q,
                               input logic dz, input logic to);
        int g = 0;
        while (!m_valid && g < 500) begin
            step();
            g++;
        end
        checks++;
        if (m_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_valid: m_valid=%b required 1", name, m_valid);
        end else begin
            checks += 3;
            if (m_quot !== q) begin
                errors++;
                $display("FAIL %s_quot: got %h required %h", name, m_quot, q);
            end
            if (m_dz !== dz) begin
                errors++;
                $display("FAIL %s_dz: got %b required %b", name, m_dz, dz);
            end
            if (m_to !== to) begin
                errors++;
                $display("FAIL %s_to: got %b required %b", name, m_to, to);
            end
        end
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks += 6;
        if (s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready: got %b required 0", s_ready); end
        if (div_rst !== 1'b1) begin errors++; $display("FAIL rst_div_rst: got %b required 1", div_rst); end
        if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid: got %b required 0", m_valid); end
        if (m_quot !== 32'h0) begin errors++; $display("FAIL rst_m_quot: got %h required 0", m_quot); end
        if (div_in_valid !== 1'b0) begin errors++; $display("FAIL rst_div_in_valid: got %b required 0", div_in_valid); end
        if ({div_N, div_D} !== 64'h0) begin errors++; $display("FAIL rst_div_nd: got %h required 0", {div_N, div_D}); end
        rst = 1'b0;
        step();
        checks += 2;
        if (s_ready !== 1'b1) begin errors++; $display("FAIL post_rst_s_ready: got %b required 1", s_ready); end
        if (div_rst !== 1'b0) begin errors++; $display("FAIL post_rst_div_rst: got %b required 0", div_rst); end
    endtask

    task automatic test_basic();
        int base_issue;
        int base_rst;
        lat = 40;
        base_issue = issue_cnt;
        base_rst   = divrst_cnt;
        push(32'h0006_0000, 32'h0002_0000);
        checks++;
        if (div_in_valid !== 1'b0) begin errors++; $display("FAIL basic_early_issue: got %b required 0", div_in_valid); end
        step();
        checks += 2;
        if (div_in_valid !== 1'b1) begin errors++; $display("FAIL basic_issue_latency: got %b required 1", div_in_valid); end
        if ({div_N, div_D} !== {32'h0006_0000, 32'h0002_0000}) begin
            errors++; $display("FAIL basic_operands: got %h required %h", {div_N, div_D}, {32'h0006_0000, 32'h0002_0000});
        end
        wait_result("basic", 32'h3000_0000, 1'b0, 1'b0);
        checks++;
        if (div_rst !== 1'b1) begin errors++; $display("FAIL basic_clear: got %b required 1", div_rst); end
        step();
        checks += 3;
        if (div_rst !== 1'b0) begin errors++; $display("FAIL basic_clear_len: got %b required 0", div_rst); end
        if (issue_cnt - base_issue !== 1) begin errors++; $display("FAIL basic_issue_count: got %0d required 1", issue_cnt - base_issue); end
        if (divrst_cnt - base_rst !== 1) begin errors++; $display("FAIL basic_div_rst_count: got %0d required 1", divrst_cnt - base_rst); end
    endtask

    task automatic test_div_zero();
        int base_issue;
        int base_rst;
        base_issue = issue_cnt;
        base_rst   = divrst_cnt;
        push(32'd5, 32'd0);
        push(-32'sd5, 32'd0);
        wait_result("dz_pos", 32'h7FFF_FFFF, 1'b1, 1'b0);
        wait_result("dz_neg", 32'h8000_0000, 1'b1, 1'b0);
        step();
        checks += 2;
        if (issue_cnt - base_issue !== 0) begin errors++; $display("FAIL dz_issue_count: got %0d required 0", issue_cnt - base_issue); end
        if (divrst_cnt - base_rst !== 0) begin errors++; $display("FAIL dz_div_rst_count: got %0d required 0", divrst_cnt - base_rst); end
    endtask

    task automatic test_back_to_back();
        int g = 0;
        lat = 20;
        hold_busy = 1'b1;
        s_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_num = 32'(3 * (i + 1) + 1);
            s_den = 32'd3;
            step();
        end
        checks++;
        if (s_ready !== 1'b0) begin errors++; $display("FAIL b2b_full: s_ready=%b required 0", s_ready); end
        s_num = 32'd16;
        s_den = 32'd3;
        hold_busy = 1'b0;
        while (!s_ready && g < 300) begin
            step();
            g++;
        end
        checks++;
        if (!s_ready) begin errors++; $display("FAIL b2b_fifth_push: s_ready=%b required 1", s_ready); end
        step();
        s_valid = 1'b0;
        wait_result("b2b_0", 32'h1000_0000, 1'b0, 1'b0);
        wait_result("b2b_1", 32'h2000_0000, 1'b0, 1'b0);
        wait_result("b2b_2", 32'h3000_0000, 1'b0, 1'b0);
        wait_result("b2b_3", 32'h4000_0000, 1'b0, 1'b0);
        wait_result("b2b_4", 32'h5000_0000, 1'b0, 1'b0);
    endtask

    task automatic test_timeout();
        int g = 0;
        int n = 0;
        never_done = 1'b1;
        push(32'd100, 32'd7);
        while (!div_in_valid && g < 50) begin
            step();
            g++;
        end
        while (!m_valid && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (n !== 65) begin errors++; $display("FAIL to_wait_cycles: got %0d required 65", n); end
        wait_result("timeout", 32'h0, 1'b0, 1'b1);
        checks++;
        if (div_rst !== 1'b1) begin errors++; $display("FAIL to_clear: got %b required 1", div_rst); end
        never_done = 1'b0;
        lat = 5;
        push(32'h20, 32'h10);
        wait_result("after_to", 32'h2000_0000, 1'b0, 1'b0);
    endtask

    task automatic test_stall_and_reset();
        int g = 0;
        int base_issue;
        int seen_valid = 0;
        lat = 3;
        push(32'd9, 32'd3);
        push(32'd8, 32'd4);
        push(32'd6, 32'd3);
        while (!m_valid && g < 200) begin
            step();
            g++;
        end
        lat = 40;
        base_issue = issue_cnt;
        for (int i = 0; i < 10; i++) begin
            checks += 2;
            if (m_valid !== 1'b1) begin errors++; $display("FAIL stall_valid_%0d: got %b required 1", i, m_valid); end
            if (m_quot !== 32'h3000_0000) begin errors++; $display("FAIL stall_quot_%0d: got %h required 30000000", i, m_quot); end
            step();
        end
        checks++;
        if (issue_cnt - base_issue !== 0) begin errors++; $display("FAIL stall_no_issue: got %0d required 0", issue_cnt - base_issue); end
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        g = 0;
        while (!div_in_valid && g < 50) begin
            step();
            g++;
        end
        for (int i = 0; i < 5; i++) step();
        rst = 1'b1;
        step();
        checks += 3;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL midrst_m_valid: got %b required 0", m_valid); end
        if (div_rst !== 1'b1) begin errors++; $display("FAIL midrst_div_rst: got %b required 1", div_rst); end
        if (s_ready !== 1'b0) begin errors++; $display("FAIL midrst_s_ready: got %b required 0", s_ready); end
        rst = 1'b0;
        step();
        base_issue = issue_cnt;
        for (int i = 0; i < 150; i++) begin
            if (m_valid) seen_valid++;
            step();
        end
        checks += 4;
        if (seen_valid !== 0) begin errors++; $display("FAIL midrst_discard: got %0d result cycles required 0", seen_valid); end
        if (issue_cnt - base_issue !== 0) begin errors++; $display("FAIL midrst_fifo_empty: got %0d issues required 0", issue_cnt - base_issue); end
        if (div_rst !== 1'b0) begin errors++; $display("FAIL midrst_div_rst_release: got %b required 0", div_rst); end
        if (overlap_cnt !== 0) begin errors++; $display("FAIL single_outstanding: got %0d overlaps required 0", overlap_cnt); end
    endtask

    initial begin
        rst     = 1'b1;
        s_valid = 1'b0;
        s_num   = '0;
        s_den   = '0;
        m_ready = 1'b0;
        test_reset();
        test_basic();
        test_div_zero();
        test_back_to_back();
        test_timeout();
        test_stall_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
